// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: default counter width,
// standard mode timings and helpers for deriving line/frame totals.
package vga_timing_pkg;

    localparam int CNT_W_DEF = 11;

    // XGA 1024x768 @ 60 Hz
    localparam int XGA_H_PIX  = 1024;
    localparam int XGA_H_FP   = 24;
    localparam int XGA_H_SYNC = 136;
    localparam int XGA_H_BP   = 160;
    localparam int XGA_V_PIX  = 768;
    localparam int XGA_V_FP   = 3;
    localparam int XGA_V_SYNC = 6;
    localparam int XGA_V_BP   = 29;

    // SVGA 800x600 @ 60 Hz
    localparam int SVGA_H_PIX  = 800;
    localparam int SVGA_H_FP   = 40;
    localparam int SVGA_H_SYNC = 128;
    localparam int SVGA_H_BP   = 88;
    localparam int SVGA_V_PIX  = 600;
    localparam int SVGA_V_FP   = 1;
    localparam int SVGA_V_SYNC = 4;
    localparam int SVGA_V_BP   = 23;

    function automatic int axis_total(input int pix, input int fp, input int sync, input int bp);
        return pix + fp + sync + bp;
    endfunction

    function automatic bit cnt_fits(input int total, input int width);
        return (width >= 31) || (total <= (1 << width));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with blank/sync decode registered from the
// next count, so the decodes always line up with the count they describe.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int PIX   = XGA_H_PIX,
    parameter int FP    = XGA_H_FP,
    parameter int SYNC  = XGA_H_SYNC,
    parameter int BP    = XGA_H_BP,
    parameter bit POL   = 1'b1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             advance,
    input  logic             restart,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             wrap
);

    localparam int               TOT     = axis_total(PIX, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOT - 1);
    localparam logic [CNT_W-1:0] BLNK_LO = CNT_W'(PIX);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(PIX + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(PIX + FP + SYNC - 1);

    logic [CNT_W-1:0] count_nxt;

    assign wrap = (count == LAST);

    always_comb begin
        count_nxt = count;
        if (restart) begin
            count_nxt = '0;
        end else if (advance) begin
            count_nxt = wrap ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= ~POL;
        end else begin
            count <= count_nxt;
            blnk  <= (count_nxt >= BLNK_LO);
            sync  <= ((count_nxt >= SYNC_LO) && (count_nxt <= SYNC_HI)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: horizontal and vertical axis counters
// plus display enable and line/frame start strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_PIX  = XGA_H_PIX,
    parameter int H_FP   = XGA_H_FP,
    parameter int H_SYNC = XGA_H_SYNC,
    parameter int H_BP   = XGA_H_BP,
    parameter int V_PIX  = XGA_V_PIX,
    parameter int V_FP   = XGA_V_FP,
    parameter int V_SYNC = XGA_V_SYNC,
    parameter int V_BP   = XGA_V_BP,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             ce,
    input  logic             resync,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = axis_total(H_PIX, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_PIX, V_FP, V_SYNC, V_BP);

    if (H_PIX < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_PIX < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1) begin : g_bad_param
        $error("vga_timing_gen: every timing parameter and CNT_W must be >= 1");
    end
    if (!cnt_fits(H_TOT, CNT_W) || !cnt_fits(V_TOT, CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOT/V_TOT");
    end

    logic h_wrap;
    logic v_wrap;
    logic resync_q;

    vga_axis_counter #(
        .PIX(H_PIX), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CNT_W(CNT_W)
    ) u_h (
        .pclk    (pclk),
        .rst     (rst),
        .advance (ce),
        .restart (resync),
        .count   (hcount),
        .blnk    (hblnk),
        .sync    (hsync),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .PIX(V_PIX), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CNT_W(CNT_W)
    ) u_v (
        .pclk    (pclk),
        .rst     (rst),
        .advance (ce & h_wrap),
        .restart (resync),
        .count   (vcount),
        .blnk    (vblnk),
        .sync    (vsync),
        .wrap    (v_wrap)
    );

    assign de = ~hblnk & ~vblnk;

    // A held resync only strobes on its first cycle, hence the resync_q edge detect.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            resync_q    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            resync_q    <= resync;
            line_start  <= resync ? ~resync_q : (ce & h_wrap);
            frame_start <= resync ? ~resync_q : (ce & h_wrap & v_wrap);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-mode raster (both polarities) against a
// linear-position model, plus an XGA async reset and line timing check.
module tb_vga_timing_gen;

    localparam int S_HT = 16;
    localparam int S_VT = 8;
    localparam int X_HT = 1344;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_x = 1'b1;
    logic        ce = 1'b0;
    logic        resync = 1'b0;

    logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount, x_hcount, x_vcount;
    logic a_hblnk, a_vblnk, a_hsync, a_vsync, a_de, a_ls, a_fs;
    logic b_hblnk, b_vblnk, b_hsync, b_vsync, b_de, b_ls, b_fs;
    logic x_hblnk, x_vblnk, x_hsync, x_vsync, x_de, x_ls, x_fs;

    int n_cmp = 0;
    int n_fail = 0;

    int pos = 0;
    bit prev_rs = 1'b0;
    bit e_ls = 1'b0;
    bit e_fs = 1'b0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_PIX(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_PIX(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
    ) dut_a (
        .pclk(pclk), .rst(rst), .ce(ce), .resync(resync),
        .hcount(a_hcount), .vcount(a_vcount), .hblnk(a_hblnk), .vblnk(a_vblnk),
        .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_PIX(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_PIX(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11)
    ) dut_b (
        .pclk(pclk), .rst(rst), .ce(ce), .resync(resync),
        .hcount(b_hcount), .vcount(b_vcount), .hblnk(b_hblnk), .vblnk(b_vblnk),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen dut_x (
        .pclk(pclk), .rst(rst_x), .ce(ce), .resync(resync),
        .hcount(x_hcount), .vcount(x_vcount), .hblnk(x_hblnk), .vblnk(x_vblnk),
        .hsync(x_hsync), .vsync(x_vsync), .de(x_de),
        .line_start(x_ls), .frame_start(x_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_small();
        int  h, v;
        bit  hb, vb, hs, vs;
        h  = pos % S_HT;
        v  = pos / S_HT;
        hb = (h >= 8);
        vb = (v >= 4);
        hs = (h >= 10 && h <= 12);
        vs = (v >= 5 && v <= 6);
        check("hcount",      a_hcount, h);
        check("vcount",      a_vcount, v);
        check("hblnk",       a_hblnk, hb);
        check("vblnk",       a_vblnk, vb);
        check("hsync",       a_hsync, hs);
        check("vsync",       a_vsync, vs);
        check("de",          a_de, (!hb && !vb));
        check("line_start",  a_ls, e_ls);
        check("frame_start", a_fs, e_fs);
        check("neg_hcount",  b_hcount, h);
        check("neg_hsync",   b_hsync, !hs);
        check("neg_vsync",   b_vsync, !vs);
        check("neg_de",      b_de, (!hb && !vb));
    endtask

    // Drive one clock with the given inputs, advance the model, then compare.
    task automatic cycle(input bit c, input bit r);
        ce = c;
        resync = r;
        @(posedge pclk);
        #1;
        if (r) begin
            e_ls = !prev_rs;
            e_fs = !prev_rs;
            pos  = 0;
        end else if (c) begin
            pos  = (pos + 1) % (S_HT * S_VT);
            e_ls = (pos % S_HT == 0);
            e_fs = (pos == 0);
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
        prev_rs = r;
        check_small();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h, first_hs, hs_width, guard;
        bit rc, rr;

        repeat (2) @(posedge pclk);
        #1;
        check_small();
        rst = 1'b0;

        repeat (3 * S_HT * S_VT) cycle(1'b1, 1'b0);

        repeat (50) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end

        guard = 0;
        while (pos != 5 * S_HT + 11 && guard < 300) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check("reach_11_5", pos, 5 * S_HT + 11);
        check("mid_hsync", a_hsync, 1'b1);
        check("mid_vsync", a_vsync, 1'b1);
        cycle(1'b1, 1'b1);
        check("resync_ls", a_ls, 1'b1);
        check("resync_fs", a_fs, 1'b1);
        repeat (5) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);

        repeat (400) begin
            rc = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 29) == 0);
            cycle(rc, rr);
        end

        ce = 1'b1;
        resync = 1'b0;
        rst_x = 1'b0;
        n = 0;
        repeat (700) begin
            @(posedge pclk);
            #1;
            n++;
            check("x_hcount_run", x_hcount, n % X_HT);
        end
        #2;
        rst_x = 1'b1;
        #1;
        check("x_rst_hcount", x_hcount, 0);
        check("x_rst_vcount", x_vcount, 0);
        check("x_rst_hblnk",  x_hblnk, 1'b0);
        check("x_rst_vblnk",  x_vblnk, 1'b0);
        check("x_rst_hsync",  x_hsync, 1'b0);
        check("x_rst_vsync",  x_vsync, 1'b0);
        check("x_rst_de",     x_de, 1'b1);
        check("x_rst_ls",     x_ls, 1'b0);
        check("x_rst_fs",     x_fs, 1'b0);
        @(negedge pclk);
        rst_x = 1'b0;

        n = 0;
        first_hs = -1;
        hs_width = 0;
        repeat (X_HT + 200) begin
            @(posedge pclk);
            #1;
            n++;
            h = n % X_HT;
            check("x_hcount", x_hcount, h);
            check("x_vcount", x_vcount, n / X_HT);
            check("x_hsync",  x_hsync, (h >= 1048 && h <= 1183));
            check("x_vsync",  x_vsync, 1'b0);
            check("x_ls",     x_ls, (h == 0));
            check("x_fs",     x_fs, 1'b0);
            if (x_hsync && first_hs < 0) first_hs = int'(x_hcount);
            if (x_hsync && n < X_HT) hs_width++;
        end
        check("x_first_hsync", first_hs, 1048);
        check("x_hsync_width", hs_width, 136);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/XGA raster timing generator. Produces pixel/line counters, blanking, sync, display-enable and frame/line start strobes for any mode set by parameters. Adds a pixel clock-enable, programmable sync polarity and a synchronous frame resync. Sits at the head of the video pipeline and feeds the draw/background/overlay stages and the VGA output register.

Parameters:
H_PIX, 1024, active pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOT = H_PIX+H_FP+H_SYNC+H_BP (1344)
V_PIX, 768, active lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOT = V_PIX+V_FP+V_SYNC+V_BP (806)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 11, counter width; must satisfy 2^CNT_W >= max(H_TOT, V_TOT)

Ports:
pclk  input  1  pixel clock
rst  input  1  reset, asynchronous, active-high
ce  input  1  pixel enable; counters advance only when 1
resync  input  1  synchronous restart of the raster at (0,0)
hcount  output  CNT_W  horizontal position, 0..H_TOT-1
vcount  output  CNT_W  vertical position, 0..V_TOT-1
hblnk  output  1  1 when hcount >= H_PIX
vblnk  output  1  1 when vcount >= V_PIX
hsync  output  1  HS_POL when hcount in [H_PIX+H_FP, H_PIX+H_FP+H_SYNC-1], else ~HS_POL
vsync  output  1  VS_POL when vcount in [V_PIX+V_FP, V_PIX+V_FP+V_SYNC-1], else ~VS_POL
de  output  1  ~hblnk & ~vblnk
line_start  output  1  one-cycle strobe on entry to hcount==0
frame_start  output  1  one-cycle strobe on entry to (hcount,vcount)==(0,0)

Behaviour:
- Reset (async assert, sync release): hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
- All outputs registered; every decode output is consistent with hcount/vcount in the same cycle (decode from the next-state counts, zero relative latency).
- Advance (ce=1, resync=0): hcount wraps H_TOT-1 -> 0, else increments. vcount changes only when hcount wraps: V_TOT-1 -> 0, else increments.
- ce=0: counters and level outputs hold. Strobes clear to 0 on the next pclk regardless of ce, so they are never longer than one pclk.
- resync=1 (priority over ce): next cycle hcount=0, vcount=0, outputs decode for (0,0), line_start=1, frame_start=1. Holding resync high keeps the raster at (0,0). Strobes pulse only on the first cycle of the hold.
- line_start=1 in the cycle hcount becomes 0 via wrap or resync. frame_start additionally requires vcount to become 0. Neither asserts when leaving reset.
- Mid-line resync truncates the current line and frame. No partial sync pulse is extended; hsync/vsync return to inactive with position (0,0).
- Counter arithmetic is CNT_W-wide unsigned. Comparisons use parameter-derived localparams. No counter exceeds *_TOT-1.
- Elaboration check: every parameter >= 1, and CNT_W is sufficient; otherwise $error.

Decomposition:
- Package vga_timing_pkg: CNT_W default, XGA 1024x768@60 and SVGA 800x600@60 mode constant sets, derived H_TOT/V_TOT functions.
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical). Parameters PIX, FP, SYNC, BP, POL. Inputs: advance, restart. Outputs: count, blnk, sync, wrap.
- The horizontal instance's wrap gates the vertical instance's advance.
- The top module forms de and the strobes.

Test Plan (small mode: H 8/2/3/3 -> H_TOT=16; V 4/1/2/1 -> V_TOT=8; POL=1 unless stated):
1. Reset then ce=1 free-run for 3 frames -> hcount 0..15 repeating; hblnk=1 for hcount 8..15; hsync=1 for hcount 10..12; vblnk=1 for vcount 4..7; vsync=1 for vcount 5..6; de matches ~hblnk&~vblnk on every cycle.
2. Strobes -> line_start=1 exactly when hcount goes 15->0 (every 16 cycles); frame_start=1 once per 128 cycles at (15,7)->(0,0); both 0 in the first cycle after reset release.
3. ce toggled 1,0,0,1 repeatedly -> counters advance only on ce=1 cycles; a strobe raised before a ce=0 cycle lasts exactly one pclk; the period in ce=1 cycles is unchanged.
4. resync pulse at (hcount,vcount)=(11,5), mid-hsync and mid-vsync -> next cycle (0,0), hsync=0, vsync=0, line_start=1, frame_start=1. Hold resync 3 cycles -> position stays (0,0) and strobes pulse once.
5. HS_POL=0, VS_POL=0 -> reset hsync=vsync=1; hsync=0 only for hcount 10..12; vsync=0 only for vcount 5..6.
6. Default XGA parameters, rst asserted mid-frame at (700,400) -> immediate async clear to reset values; after release, first hsync assertion at hcount 1048 for 136 cycles; vsync for lines 771..776; frame period 1344*806 = 1,083,264 cycles.
